sha1_base_ocimem_arb_seq: RTL and testbench
===========================================

Name: sha1_base_ocimem_arb_seq

Overview:
- Sequences and arbitrates access to the Nios II on-chip debug memory (OCI RAM) in the system-clock domain.
- Two requesters share one single-port RAM:
  - the JTAG debug path, via the take_action_ocimem_a/b strobes and jdo from the sysclk half of the debug slave;
  - the Avalon debug_mem slave port used by the CPU.
- Round-robin arbitration between the two.
- Holds the JTAG address register and the monitor data register (MonDReg) for JTAG reads.

Parameters:
- ADDR_W, 8, OCI RAM word-address width (256 x 32).
- DATA_W, 32, RAM and Avalon data width; must be 32 because the jdo field mapping below is fixed.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- take_action_ocimem_a  in  1  one-cycle strobe: load JTAG address from jdo
- take_action_ocimem_b  in  1  one-cycle strobe: JTAG data op (read or write)
- jdo  in  38  JTAG data: jdo[ADDR_W+1:2] = address; jdo[35] = write flag; jdo[34:3] = write data
- av_address  in  ADDR_W  Avalon word address
- av_read  in  1  Avalon read request
- av_write  in  1  Avalon write request
- av_writedata  in  32  Avalon write data
- av_waitrequest  out  1  Avalon stall
- av_readdata  out  32  Avalon read data, valid when av_read is high and av_waitrequest is low
- ram_addr  out  ADDR_W  RAM address
- ram_wren  out  1  RAM write enable
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data; registered, 1-cycle latency
- MonDReg  out  32  last JTAG read result
- jtag_busy  out  1  JTAG op pending or in flight

Behaviour:
- Reset values (applied when reset_n is sampled low): all outputs 0 except av_waitrequest = 1; state = IDLE; jtag_addr = 0; jtag_pend = 0; last_grant = AV.
- take_action_ocimem_a:
  - jtag_addr <= jdo[ADDR_W+1:2].
  - If it coincides with take_action_ocimem_b, the address load occurs first and the data op uses the new address.
- take_action_ocimem_b:
  - sets jtag_pend and latches jtag_wr = jdo[35] and jtag_wdata = jdo[34:3].
  - A strobe arriving while jtag_pend = 1 is dropped. The upstream debugger polls jtag_busy, so this never occurs in legal use.
- jtag_busy = jtag_pend or (state is JT_WR or JT_RD or JT_RDATA).
- State machine:
  - IDLE -> AV_WR, AV_RD, JT_WR or JT_RD by the arbitration rule below.
  - AV_WR: drive ram_addr = av_address, ram_wren = 1, ram_wdata = av_writedata; av_waitrequest = 0 this cycle; -> IDLE.
  - AV_RD: drive ram_addr = av_address; -> AV_RDATA.
  - AV_RDATA: av_readdata <= ram_rdata (registered); -> AV_DONE.
  - AV_DONE: av_waitrequest = 0 for exactly one cycle; -> IDLE.
  - JT_WR: RAM write of jtag_wdata to jtag_addr; clear jtag_pend; -> IDLE.
  - JT_RD: drive ram_addr = jtag_addr; -> JT_RDATA.
  - JT_RDATA: MonDReg <= ram_rdata; clear jtag_pend; -> IDLE.
- Latency from grant cycle: Avalon write 1 cycle, Avalon read 3 cycles; JTAG write 1 cycle, JTAG read 2 cycles.
- Arbitration, evaluated only in IDLE:
  - Requesters are av_req = av_read | av_write, and jtag_pend.
  - With one requester, grant it.
  - With both, grant the one that is not last_grant. Update last_grant on every grant.
  - av_read and av_write both high: treated as a write.
- av_waitrequest is 1 in every state except the Avalon completion cycle (AV_WR or AV_DONE).
- Avalon master rule: address and data are held stable while av_waitrequest = 1; the block samples them in the grant state only.
- ram_wren is 0 in every state except AV_WR and JT_WR.
- Address wrap: jtag_addr arithmetic is modulo 2^ADDR_W.
- Reset mid-operation: the FSM returns to IDLE, the pending op is discarded, no RAM write is issued in the reset cycle, and av_waitrequest returns to 1.

Optional Feature:
- Macro: SHA1_BASE_OCIMEM_AUTOINC_EN.
- Defined: after each completed JTAG op (JT_WR or JT_RDATA), jtag_addr <= jtag_addr + 1, wrapping from 2^ADDR_W-1 to 0. A take_action_ocimem_a in the same cycle has priority over the increment.
- Undefined: jtag_addr changes only on take_action_ocimem_a.

Decomposition:
- Package sha1_base_ocimem_pkg contains:
  - state enum (IDLE, AV_WR, AV_RD, AV_RDATA, AV_DONE, JT_WR, JT_RD, JT_RDATA);
  - grant enum (AV, JT);
  - jdo field localparams (JDO_WR_BIT = 35, JDO_DATA_LSB = 3, JDO_ADDR_LSB = 2).
- One sub-module: sha1_base_ocimem_rr_arb, a 2-requester round-robin arbiter with a last_grant register; inputs req[1:0] and an enable, output one-hot gnt.

Test Plan:
- Reset, then Avalon write 0xDEADBEEF to address 0x10, then Avalon read of 0x10 -> write completes after 1 waitrequest-low cycle; read returns 0xDEADBEEF with av_waitrequest low 3 cycles after grant.
- take_action_ocimem_a with address 0x20; take_action_ocimem_b with jdo[35] = 1 and data 0x12345678; then a JTAG read of 0x20 -> MonDReg = 0x12345678; jtag_busy is low 1 cycle after JT_RDATA.
- jtag_pend set and av_read asserted in the same cycle with last_grant = AV -> JTAG is granted first, Avalon second; repeat with both held -> grants alternate JT, AV, JT.
- With SHA1_BASE_OCIMEM_AUTOINC_EN, address 0xFF, three JTAG writes A, B, C -> RAM[0xFF] = A, RAM[0x00] = B, RAM[0x01] = C. Without the macro: RAM[0xFF] = C.
- reset_n driven low in the AV_RDATA cycle -> next cycle state is IDLE, av_waitrequest = 1, ram_wren = 0, and the read never completes.
- take_action_ocimem_a and take_action_ocimem_b in the same cycle with address 0x05 and a write -> the write lands at 0x05, not at the previous address.

Source files
------------

// File: rtl/sha1_base_ocimem_pkg.sv
// Shared types and jdo field positions for the OCI RAM arbiter/sequencer.
package sha1_base_ocimem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    AV_WR,
    AV_RD,
    AV_RDATA,
    AV_DONE,
    JT_WR,
    JT_RD,
    JT_RDATA
  } state_e;

  typedef enum logic {
    AV = 1'b0,
    JT = 1'b1
  } grant_e;

  localparam int JDO_WR_BIT   = 35;
  localparam int JDO_DATA_LSB = 3;
  localparam int JDO_ADDR_LSB = 2;

  // Bit positions of the two requesters in the arbiter req/gnt vectors
  localparam int REQ_AV = 0;
  localparam int REQ_JT = 1;

endpackage

// File: rtl/sha1_base_ocimem_rr_arb.sv
// Two-requester round-robin arbiter; the last winner loses a tie on the next decision.
module sha1_base_ocimem_rr_arb
  import sha1_base_ocimem_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  grant_e last_q, last_d;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      last_q <= AV;
    end else begin
      last_q <= last_d;
    end
  end

  always_comb begin
    gnt_o  = 2'b00;
    last_d = last_q;
    if (en_i) begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = (last_q == AV) ? 2'b10 : 2'b01;
        default: gnt_o = 2'b00;
      endcase
      if (gnt_o[REQ_JT]) begin
        last_d = JT;
      end else if (gnt_o[REQ_AV]) begin
        last_d = AV;
      end
    end
  end

endmodule

// File: rtl/sha1_base_ocimem_arb_seq.sv
// Sequences JTAG debug and Avalon debug_mem accesses onto the single-port OCI RAM.
// Optional: define SHA1_BASE_OCIMEM_AUTOINC_EN to post-increment the JTAG address after each JTAG op.
module sha1_base_ocimem_arb_seq
  import sha1_base_ocimem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [37:0]       jdo,
  input  logic [ADDR_W-1:0] av_address,
  input  logic              av_read,
  input  logic              av_write,
  input  logic [DATA_W-1:0] av_writedata,
  output logic              av_waitrequest,
  output logic [DATA_W-1:0] av_readdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] MonDReg,
  output logic              jtag_busy
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   jtag_addr_q, jtag_addr_d;
  logic                jtag_pend_q, jtag_pend_d;
  logic                jtag_wr_q, jtag_wr_d;
  logic [DATA_W-1:0]   jtag_wdata_q, jtag_wdata_d;
  logic [DATA_W-1:0]   mondreg_q, mondreg_d;
  logic [DATA_W-1:0]   av_rdata_q, av_rdata_d;
  logic [1:0]          gnt;
  logic                jtag_done;
  logic                unused_jdo;

  assign unused_jdo = ^{jdo[37:36], jdo[1:0]};
  assign jtag_done  = (state_q == JT_WR) || (state_q == JT_RDATA);

  sha1_base_ocimem_rr_arb u_arb (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .en_i      (state_q == IDLE),
    .req_i     ({jtag_pend_q, av_read | av_write}),
    .gnt_o     (gnt)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      jtag_addr_q  <= '0;
      jtag_pend_q  <= 1'b0;
      jtag_wr_q    <= 1'b0;
      jtag_wdata_q <= '0;
      mondreg_q    <= '0;
      av_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      jtag_addr_q  <= jtag_addr_d;
      jtag_pend_q  <= jtag_pend_d;
      jtag_wr_q    <= jtag_wr_d;
      jtag_wdata_q <= jtag_wdata_d;
      mondreg_q    <= mondreg_d;
      av_rdata_q   <= av_rdata_d;
    end
  end

  // A simultaneous read+write from the Avalon side is serviced as a write
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (gnt[REQ_AV]) begin
          state_d = av_write ? AV_WR : AV_RD;
        end else if (gnt[REQ_JT]) begin
          state_d = jtag_wr_q ? JT_WR : JT_RD;
        end
      end
      AV_WR:    state_d = IDLE;
      AV_RD:    state_d = AV_RDATA;
      AV_RDATA: state_d = AV_DONE;
      AV_DONE:  state_d = IDLE;
      JT_WR:    state_d = IDLE;
      JT_RD:    state_d = JT_RDATA;
      JT_RDATA: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    jtag_addr_d = jtag_addr_q;
`ifdef SHA1_BASE_OCIMEM_AUTOINC_EN
    if (jtag_done) begin
      jtag_addr_d = jtag_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    end
`endif
    if (take_action_ocimem_a) begin
      jtag_addr_d = jdo[JDO_ADDR_LSB +: ADDR_W];
    end
  end

  // Pending JTAG op: a new strobe is only accepted once the previous op has retired
  always_comb begin
    jtag_pend_d  = jtag_pend_q;
    jtag_wr_d    = jtag_wr_q;
    jtag_wdata_d = jtag_wdata_q;
    if (jtag_done) begin
      jtag_pend_d = 1'b0;
    end
    if (take_action_ocimem_b && !jtag_pend_q) begin
      jtag_pend_d  = 1'b1;
      jtag_wr_d    = jdo[JDO_WR_BIT];
      jtag_wdata_d = jdo[JDO_DATA_LSB +: DATA_W];
    end
  end

  always_comb begin
    mondreg_d  = (state_q == JT_RDATA) ? ram_rdata : mondreg_q;
    av_rdata_d = (state_q == AV_RDATA) ? ram_rdata : av_rdata_q;
  end

  // RAM write enable is gated by reset so an op caught by reset never commits
  always_comb begin
    ram_addr       = '0;
    ram_wren       = 1'b0;
    ram_wdata      = '0;
    av_waitrequest = 1'b1;
    case (state_q)
      AV_WR: begin
        ram_addr       = av_address;
        ram_wren       = reset_n;
        ram_wdata      = av_writedata;
        av_waitrequest = 1'b0;
      end
      AV_RD:   ram_addr = av_address;
      AV_DONE: av_waitrequest = 1'b0;
      JT_WR: begin
        ram_addr  = jtag_addr_q;
        ram_wren  = reset_n;
        ram_wdata = jtag_wdata_q;
      end
      JT_RD:   ram_addr = jtag_addr_q;
      default: ;
    endcase
  end

  assign jtag_busy   = jtag_pend_q || (state_q == JT_WR) || (state_q == JT_RD) ||
                       (state_q == JT_RDATA);
  assign MonDReg     = mondreg_q;
  assign av_readdata = av_rdata_q;

endmodule

// File: tb/tb_sha1_base_ocimem_arb_seq.sv
// Self-checking bench for sha1_base_ocimem_arb_seq with a behavioural RAM and memory model.
// Honours SHA1_BASE_OCIMEM_AUTOINC_EN when computing expected JTAG addresses.
module tb_sha1_base_ocimem_arb_seq;

  typedef struct {
    bit          wr;
    bit          rdToo;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [31:0] expRead;
    int          expLat;
  } avVec_t;

  logic        clk = 1'b0;
  logic        resetN;
  logic        takeA, takeB;
  logic [37:0] jdo;
  logic [7:0]  avAddress;
  logic        avRead, avWrite;
  logic [31:0] avWritedata;
  logic        avWaitrequest;
  logic [31:0] avReaddata;
  logic [7:0]  ramAddr;
  logic        ramWren;
  logic [31:0] ramWdata;
  logic [31:0] ramRdata;
  logic [31:0] monDReg;
  logic        jtagBusy;

  int          nCompared   = 0;
  int          nMismatched = 0;

  bit   [31:0] ram [256];
  bit   [31:0] expMem [256];
  int          modelJtagAddr = 0;
  logic [31:0] expMonD = '0;

  bit          logEn = 1'b0;
  bit          grantLog [$];

  always #5 clk = ~clk;

  sha1_base_ocimem_arb_seq dut (
    .clk                  (clk),
    .reset_n              (resetN),
    .take_action_ocimem_a (takeA),
    .take_action_ocimem_b (takeB),
    .jdo                  (jdo),
    .av_address           (avAddress),
    .av_read              (avRead),
    .av_write             (avWrite),
    .av_writedata         (avWritedata),
    .av_waitrequest       (avWaitrequest),
    .av_readdata          (avReaddata),
    .ram_addr             (ramAddr),
    .ram_wren             (ramWren),
    .ram_wdata            (ramWdata),
    .ram_rdata            (ramRdata),
    .MonDReg              (monDReg),
    .jtag_busy            (jtagBusy)
  );

  // Single-port RAM with registered read data
  always @(posedge clk) begin
    if (ramWren) ram[ramAddr] <= ramWdata;
    ramRdata <= ram[ramAddr];
  end

  // Each RAM write cycle records who owned it: waitrequest high means JTAG
  always @(negedge clk) begin
    if (logEn && ramWren) grantLog.push_back(avWaitrequest);
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time exhausted");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model of one retired JTAG op
  task automatic modelJtag(input bit wr, input logic [31:0] data);
    if (wr) expMem[modelJtagAddr] = data;
    else    expMonD = expMem[modelJtagAddr];
`ifdef SHA1_BASE_OCIMEM_AUTOINC_EN
    modelJtagAddr = (modelJtagAddr + 1) % 256;
`endif
  endtask

  task automatic doReset(input bit fullCheck);
    resetN = 1'b0; takeA = 1'b0; takeB = 1'b0; jdo = '0;
    avAddress = '0; avRead = 1'b0; avWrite = 1'b0; avWritedata = '0;
    tick();
    tick();
    if (fullCheck) begin
      checkOutput("rstWaitreq", {31'd0, avWaitrequest}, 32'd1);
      checkOutput("rstWren", {31'd0, ramWren}, 32'd0);
      checkOutput("rstRamAddr", {24'd0, ramAddr}, 32'd0);
      checkOutput("rstMonDReg", monDReg, 32'd0);
      checkOutput("rstBusy", {31'd0, jtagBusy}, 32'd0);
      checkOutput("rstReaddata", avReaddata, 32'd0);
    end
    resetN = 1'b1;
    modelJtagAddr = 0;
    expMonD = '0;
    tick();
  endtask

  task automatic applyStimulus(input bit wr, input bit rdToo, input logic [7:0] addr,
                               input logic [31:0] data, output logic [31:0] rdata, output int lat);
    bit done = 1'b0;
    avAddress = addr; avWritedata = data; avWrite = wr; avRead = !wr || rdToo;
    lat = 0;
    rdata = '0;
    while (!done && lat < 50) begin
      tick();
      lat++;
      if (!avWaitrequest) done = 1'b1;
    end
    checkOutput("avHandshake", {31'd0, done}, 32'd1);
    rdata = avReaddata;
    tick();
    avWrite = 1'b0; avRead = 1'b0;
    if (wr) expMem[addr] = data;
  endtask

  task automatic jtagSetAddr(input logic [7:0] addr);
    jdo = '0;
    jdo[9:2] = addr;
    takeA = 1'b1;
    tick();
    takeA = 1'b0;
    modelJtagAddr = int'(addr);
  endtask

  task automatic waitJtagIdle(output int busyCycles);
    busyCycles = 0;
    while (jtagBusy && busyCycles < 50) begin
      tick();
      busyCycles++;
    end
    checkOutput("jtagIdle", {31'd0, jtagBusy}, 32'd0);
  endtask

  task automatic jtagOp(input bit wr, input logic [31:0] data, output int busyCycles);
    jdo = '0;
    jdo[35] = wr;
    jdo[34:3] = data;
    takeB = 1'b1;
    tick();
    takeB = 1'b0;
    waitJtagIdle(busyCycles);
    modelJtag(wr, data);
  endtask

  avVec_t      vecs [10];
  logic [31:0] rd;
  int          lat, busyCyc, lowCount, logStart, op;
  logic [7:0]  rAddr;
  logic [31:0] rData;
  bit          done;

  initial begin
    vecs[0] = '{1'b1, 1'b0, 8'h10, 32'hDEADBEEF, 32'h0,        1};
    vecs[1] = '{1'b0, 1'b0, 8'h10, 32'h0,        32'hDEADBEEF, 3};
    vecs[2] = '{1'b1, 1'b0, 8'h11, 32'hCAFEF00D, 32'h0,        1};
    vecs[3] = '{1'b1, 1'b0, 8'hFF, 32'hA5A5A5A5, 32'h0,        1};
    vecs[4] = '{1'b0, 1'b0, 8'h11, 32'h0,        32'hCAFEF00D, 3};
    vecs[5] = '{1'b0, 1'b0, 8'hFF, 32'h0,        32'hA5A5A5A5, 3};
    vecs[6] = '{1'b1, 1'b1, 8'h10, 32'h01234567, 32'h0,        1};
    vecs[7] = '{1'b0, 1'b0, 8'h10, 32'h0,        32'h01234567, 3};
    vecs[8] = '{1'b0, 1'b0, 8'h00, 32'h0,        32'h00000000, 3};
    vecs[9] = '{1'b0, 1'b0, 8'h12, 32'h0,        32'h00000000, 3};

    doReset(1'b1);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].wr, vecs[i].rdToo, vecs[i].addr, vecs[i].data, rd, lat);
      checkOutput($sformatf("vec%0dLat", i), lat, vecs[i].expLat);
      if (!vecs[i].wr) checkOutput($sformatf("vec%0dData", i), rd, vecs[i].expRead);
    end

    // JTAG write then read back through MonDReg
    jtagSetAddr(8'h20);
    jtagOp(1'b1, 32'h12345678, busyCyc);
    checkOutput("jtWrBusy", busyCyc, 2);
    jtagSetAddr(8'h20);
    jtagOp(1'b0, 32'h0, busyCyc);
    checkOutput("jtRdBusy", busyCyc, 3);
    checkOutput("jtRdMonD", monDReg, 32'h12345678);

    // Address wrap, with or without auto-increment
    jtagSetAddr(8'hFF);
    jtagOp(1'b1, 32'hAAAA0001, busyCyc);
    jtagOp(1'b1, 32'hBBBB0002, busyCyc);
    jtagOp(1'b1, 32'hCCCC0003, busyCyc);
    applyStimulus(1'b0, 1'b0, 8'hFF, 32'h0, rd, lat);
`ifdef SHA1_BASE_OCIMEM_AUTOINC_EN
    checkOutput("wrapFF", rd, 32'hAAAA0001);
    applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, rd, lat);
    checkOutput("wrap00", rd, 32'hBBBB0002);
    applyStimulus(1'b0, 1'b0, 8'h01, 32'h0, rd, lat);
    checkOutput("wrap01", rd, 32'hCCCC0003);
`else
    checkOutput("wrapFF", rd, 32'hCCCC0003);
    applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, rd, lat);
    checkOutput("wrap00", rd, 32'h00000000);
`endif

    // Same-cycle address load and write: data field low bits overlap the address field
    jtagSetAddr(8'h40);
    jdo = '0;
    jdo[35] = 1'b1;
    jdo[34:3] = 32'hABCD0002;
    jdo[9:2] = 8'h05;
    takeA = 1'b1; takeB = 1'b1;
    tick();
    takeA = 1'b0; takeB = 1'b0;
    modelJtagAddr = 5;
    waitJtagIdle(busyCyc);
    modelJtag(1'b1, 32'hABCD0002);
    applyStimulus(1'b0, 1'b0, 8'h05, 32'h0, rd, lat);
    checkOutput("abAddr05", rd, 32'hABCD0002);
    applyStimulus(1'b0, 1'b0, 8'h40, 32'h0, rd, lat);
    checkOutput("abAddr40", rd, 32'h00000000);

    // Reset in the Avalon write cycle must suppress the RAM write
    avAddress = 8'h60; avWritedata = 32'h66666666; avWrite = 1'b1;
    tick();
    resetN = 1'b0;
    #1;
    checkOutput("rstWrWren", {31'd0, ramWren}, 32'd0);
    tick();
    avWrite = 1'b0;
    checkOutput("rstWrWaitreq", {31'd0, avWaitrequest}, 32'd1);
    resetN = 1'b1;
    modelJtagAddr = 0; expMonD = '0;
    tick();

    // Reset in AV_RDATA: read is abandoned
    avAddress = 8'h10; avRead = 1'b1;
    tick();
    tick();
    resetN = 1'b0; avRead = 1'b0;
    tick();
    checkOutput("rstRdWaitreq", {31'd0, avWaitrequest}, 32'd1);
    checkOutput("rstRdWren", {31'd0, ramWren}, 32'd0);
    checkOutput("rstRdReaddata", avReaddata, 32'd0);
    resetN = 1'b1;
    lowCount = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!avWaitrequest) lowCount++;
    end
    checkOutput("rstRdNoComplete", lowCount, 0);
    applyStimulus(1'b0, 1'b0, 8'h60, 32'h0, rd, lat);
    checkOutput("rstWrDropped", rd, 32'h00000000);

    // Randomised traffic against the memory model
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 4);
      rAddr = 8'($urandom_range(0, 7)) | ($urandom_range(0, 1) ? 8'hF8 : 8'h00);
      rData = $urandom;
      case (op)
        0: begin
          applyStimulus(1'b1, 1'b0, rAddr, rData, rd, lat);
          checkOutput("rndAvWrLat", lat, 1);
        end
        1: begin
          applyStimulus(1'b0, 1'b0, rAddr, 32'h0, rd, lat);
          checkOutput("rndAvRdLat", lat, 3);
          checkOutput("rndAvRdData", rd, expMem[rAddr]);
        end
        2: jtagSetAddr(rAddr);
        3: begin
          jtagOp(1'b1, rData, busyCyc);
          checkOutput("rndJtWrBusy", busyCyc, 2);
        end
        default: begin
          jtagOp(1'b0, 32'h0, busyCyc);
          checkOutput("rndJtRdBusy", busyCyc, 3);
          checkOutput("rndJtRdMonD", monDReg, expMonD);
        end
      endcase
    end

    // Contention after reset: JTAG wins first, Avalon read completes second
    doReset(1'b0);
    logStart = grantLog.size();
    logEn = 1'b1;
    jdo = '0; jdo[35] = 1'b1; jdo[34:3] = 32'h00000077;
    takeB = 1'b1;
    tick();
    takeB = 1'b0;
    avAddress = 8'h10; avRead = 1'b1;
    lat = 0; done = 1'b0;
    while (!done && lat < 50) begin
      tick();
      lat++;
      if (!avWaitrequest) done = 1'b1;
    end
    rd = avReaddata;
    tick();
    avRead = 1'b0;
    modelJtag(1'b1, 32'h00000077);
    checkOutput("arbAvLat", lat, 5);
    checkOutput("arbAvData", rd, expMem[8'h10]);
    checkOutput("arbLogSize", grantLog.size() - logStart, 1);
    if (grantLog.size() > logStart) checkOutput("arbFirstJt", {31'd0, grantLog[logStart]}, 32'd1);

    // Both requesters kept busy: grants alternate JT, AV, JT, ...
    logStart = grantLog.size();
    jdo = '0; jdo[35] = 1'b1; jdo[34:3] = 32'h0000BEEF;
    takeB = 1'b1;
    tick();
    takeB = 1'b0;
    avAddress = 8'h31; avWritedata = 32'h31313131; avWrite = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (!jtagBusy && !takeB) takeB = 1'b1;
      else takeB = 1'b0;
    end
    takeB = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      if (!avWaitrequest) done = 1'b1;
      tick();
    end
    avWrite = 1'b0;
    checkOutput("altAvDone", {31'd0, done}, 32'd1);
    waitJtagIdle(busyCyc);
    logEn = 1'b0;
    checkOutput("altLogEnough", {31'd0, (grantLog.size() - logStart) >= 6}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      if (logStart + i < grantLog.size())
        checkOutput($sformatf("altGrant%0d", i), {31'd0, grantLog[logStart + i]},
                    {31'd0, (i % 2) == 0});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
